// File: rtl/rapcla_pkg.sv
// Shared types and sizing helpers for the sequential RAP approximate/exact adder.
package rapcla_pkg;

   typedef enum logic [1:0] {IDLE, EXACT, DONE} state_e;

   localparam int SEG_W_MIN = 1;

   function automatic int nseg(input int width, input int win);
      return (width + win - 1) / win;
   endfunction

   // Segment-counter width: enough to index every slice, never zero bits wide.
   function automatic int seg_w(input int width, input int win);
      int n;
      n = nseg(width, win);
      return (n > 1) ? $clog2(n) : SEG_W_MIN;
   endfunction

endpackage

// File: rtl/rapcla_approx_core.sv
// Combinational RAP approximate adder: each carry only sees generates within WIN
// positions below it, so carry chains longer than the window are truncated.
module rapcla_approx_core #(
   parameter int WIDTH = 16,
   parameter int WIN   = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH:0]   sum_o
);

   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] appc;
   logic             run;

   always_comb begin
      p    = a_i ^ b_i;
      g    = a_i & b_i;
      appc = '0;
      run  = 1'b1;
      // Walk down from bit i, accumulating the propagate product above each generate.
      for (int i = 0; i < WIDTH; i++) begin
         run = 1'b1;
         for (int j = i; j >= 0; j--) begin
            if (j >= i - WIN) begin
               appc[i] = appc[i] | (g[j] & run);
               run     = run & p[j];
            end
         end
      end
   end

   always_comb begin
      sum_o        = '0;
      sum_o[0]     = p[0];
      for (int i = 1; i < WIDTH; i++) begin
         sum_o[i] = p[i] ^ appc[i-1];
      end
      sum_o[WIDTH] = appc[WIDTH-1];
   end

endmodule

// File: rtl/rapcla_seq.sv
// Sequential adder with runtime mode: single-cycle RAP approximation or exact
// WIN-bit segment-serial ripple. Define RAP_ERRFLAG_EN to add the err output.
module rapcla_seq
   import rapcla_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int WIN   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
`ifdef RAP_ERRFLAG_EN
   ,
   output logic             err
`endif
);

   localparam int NSEG  = nseg(WIDTH, WIN);
   localparam int SEG_W = seg_w(WIDTH, WIN);
   localparam int PW    = NSEG * WIN;

   state_e           state_q, state_d;
   logic [PW-1:0]    a_q, a_d;
   logic [PW-1:0]    b_q, b_d;
   logic [PW:0]      sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [SEG_W-1:0] seg_q, seg_d;
   logic [WIDTH:0]   approx_sum;
   logic [WIN:0]     slice_sum;
   logic             accept;

   rapcla_approx_core #(.WIDTH(WIDTH), .WIN(WIN)) u_core (
      .a_i   (a),
      .b_i   (b),
      .sum_o (approx_sum)
   );

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign sum       = sum_q[WIDTH:0];

   // Operands are zero-padded to whole slices, so a narrow last slice needs no special case.
   assign slice_sum = {1'b0, a_q[int'(seg_q)*WIN +: WIN]}
                    + {1'b0, b_q[int'(seg_q)*WIN +: WIN]}
                    + (WIN+1)'(carry_q);

`ifdef RAP_ERRFLAG_EN
   logic           err_q, err_d;
   logic [WIDTH:0] exact_ref;
   assign exact_ref = {1'b0, a} + {1'b0, b};
   assign err       = err_q;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      seg_d   = seg_q;
`ifdef RAP_ERRFLAG_EN
      err_d   = err_q;
`endif
      case (state_q)
         EXACT: begin
            sum_d[int'(seg_q)*WIN +: WIN] = slice_sum[WIN-1:0];
            carry_d = slice_sum[WIN];
            seg_d   = seg_q + SEG_W'(1);
            if (seg_q == SEG_W'(NSEG-1)) begin
               sum_d[PW] = slice_sum[WIN];
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready && !accept) state_d = IDLE;
         end
         default: ;
      endcase
      if (accept) begin
         if (mode) begin
            a_d     = PW'(a);
            b_d     = PW'(b);
            carry_d = 1'b0;
            seg_d   = '0;
            state_d = EXACT;
`ifdef RAP_ERRFLAG_EN
            err_d   = 1'b0;
`endif
         end else begin
            sum_d   = (PW+1)'(approx_sum);
            state_d = DONE;
`ifdef RAP_ERRFLAG_EN
            err_d   = (approx_sum != exact_ref);
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         seg_q   <= '0;
`ifdef RAP_ERRFLAG_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         seg_q   <= seg_d;
`ifdef RAP_ERRFLAG_EN
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_rapcla_seq.sv
// Scoreboard bench for rapcla_seq: directed cases plus randomized mixed-mode traffic.
module tb_rapcla_seq;

   localparam int W   = 16;
   localparam int WIN = 4;

   typedef struct packed {
      logic [W:0] sum;
      logic       err;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         mode;
   logic         out_valid;
   logic         out_ready;
   logic [W:0]   sum;
`ifdef RAP_ERRFLAG_EN
   logic         err;
`endif

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   n_push = 0;
   int   n_pop  = 0;
   int   n_drop = 0;

   rapcla_seq #(.WIDTH(W), .WIN(WIN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
`ifdef RAP_ERRFLAG_EN
      ,
      .err       (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: carry into bit i+1 is any generate at j in [i-WIN, i] whose
   // propagates p[j+1..i] are all set.
   function automatic logic [W:0] approx_ref(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] p, g, c;
      logic [W:0]   r;
      logic         term;
      p = x ^ y;
      g = x & y;
      c = '0;
      for (int i = 0; i < W; i++) begin
         for (int j = (i > WIN ? i - WIN : 0); j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            c[i] = c[i] | term;
         end
      end
      r[0] = p[0];
      for (int i = 1; i < W; i++) r[i] = p[i] ^ c[i-1];
      r[W] = c[W-1];
      return r;
   endfunction

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
      exp_t       e;
      logic [W:0] ex;
      ex = {1'b0, x} + {1'b0, y};
      if (m) begin
         e.sum = ex;
         e.err = 1'b0;
      end else begin
         e.sum = approx_ref(x, y);
         e.err = (e.sum != ex);
      end
      return e;
   endfunction

   // Stimulus side of the scoreboard: record the expectation of every accepted op.
   always @(negedge clk) begin
      if (rst) begin
         n_drop += sb.size();
         sb.delete();
      end else if (in_valid && in_ready) begin
         sb.push_back(model(a, b, mode));
         n_push++;
      end
   end

   // Checking side: every presented-and-consumed result must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            n_pop++;
            check("sb_sum", 32'(sum), 32'(e.sum));
`ifdef RAP_ERRFLAG_EN
            check("sb_err", 32'(err), 32'(e.err));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic got;
      int   guard;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef RAP_ERRFLAG_EN
      check("rst_err", 32'(err), 32'd0);
`endif

      // Approximate, carry chain longer than the window.
      in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; mode = 1'b0;
      tick();
      in_valid = 1'b0;
      check("t1_latency", 32'(out_valid), 32'd1);
      check("t1_sum", 32'(sum), 32'h000C0);
`ifdef RAP_ERRFLAG_EN
      check("t1_err", 32'(err), 32'd1);
`endif
      tick();

      in_valid = 1'b1; a = 16'h1234; b = 16'h4321; mode = 1'b0;
      tick();
      in_valid = 1'b0;
      check("t2_sum", 32'(sum), 32'h05555);
`ifdef RAP_ERRFLAG_EN
      check("t2_err", 32'(err), 32'd0);
`endif
      tick();

      // Exact: four slices, operands scrambled after accept.
      in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; mode = 1'b1;
      tick();
      in_valid = 1'b0; a = 16'hA5A5; b = 16'h5A5A; mode = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("t3_busy", 32'(out_valid), 32'd0);
         tick();
      end
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_sum", 32'(sum), 32'h10000);
`ifdef RAP_ERRFLAG_EN
      check("t3_err", 32'(err), 32'd0);
`endif
      tick();

      // Output stall, then back-to-back accept on release.
      out_ready = 1'b0;
      in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; mode = 1'b0;
      tick();
      a = 16'h0003; b = 16'h0005; mode = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("t4_valid", 32'(out_valid), 32'd1);
         check("t4_in_ready", 32'(in_ready), 32'd0);
         check("t4_sum", 32'(sum), 32'h0FFC0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("t4_release_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("t4_b2b_valid", 32'(out_valid), 32'd1);
      check("t4_b2b_sum", 32'(sum), 32'h00008);
      tick();

      // Reset in the 2nd EXACT cycle discards the operation.
      in_valid = 1'b1; a = 16'h7777; b = 16'h1111; mode = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_sum", 32'(sum), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; a = 16'h0003; b = 16'h0005; mode = 1'b0;
      tick();
      in_valid = 1'b0;
      check("t5_sum_after", 32'(sum), 32'h00008);
      tick();
      for (int k = 0; k < 6; k++) begin
         check("t5_no_stale", 32'(out_valid), 32'd0);
         tick();
      end

      // Randomized mixed-mode traffic with random consumer back-pressure.
      for (int n = 0; n < 1000; n++) begin
         in_valid = 1'b1;
         a    = 16'($urandom);
         b    = 16'($urandom);
         mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
         if ($urandom_range(0, 7) == 0) b = 16'h0001;
         got = 1'b0;
         guard = 0;
         while (!got && guard < 200) begin
            @(negedge clk);
            got = in_ready;
            tick();
            out_ready = ($urandom_range(0, 3) != 0);
            guard++;
         end
         check("rand_accept", 32'(got), 32'd1);
         if (!got) break;
         in_valid = 1'b0;
         a = 16'($urandom);
         b = 16'($urandom);
         repeat ($urandom_range(0, 2)) begin
            tick();
            out_ready = ($urandom_range(0, 3) != 0);
         end
      end

      out_ready = 1'b1;
      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         tick();
         guard++;
      end
      tick();
      check("drain_empty", 32'(sb.size()), 32'd0);
      check("result_count", 32'(n_pop), 32'(n_push - n_drop));
      check("final_idle", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rapcla_seq.md
Name: rapcla_seq

Overview:
- Parametrised successor to the fixed-width, fixed-window RAP approximate carry-lookahead adder.
- Adds a runtime mode select: approximate (single-pass truncated carry window) or exact (segment-serial ripple over WIN-bit slices).
- Valid/ready handshakes on input and output.
- Sits between operand registers and accumulator/consumer logic in error-resilient datapaths.

Parameters:
- WIDTH, 16, operand width in bits (>=2).
- WIN, 4, carry window: max number of lower positions whose generate can reach bit i (1..WIDTH-1); also the exact-mode segment width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand transfer request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- mode  in  1  0 = approximate, 1 = exact; sampled with operands
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH+1  registered result
- err  out  1  only with RAP_ERRFLAG_EN; see Optional Feature

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state IDLE, out_valid=0, sum=0, err=0, carry and segment registers 0.
- Approximate function, with p=a^b and g=a&b:
  - appc[i] = OR over j=max(0,i-WIN)..i of (g[j] & AND p[j+1..i]).
  - sum[0]=p[0]; sum[i]=p[i]^appc[i-1] for i in 1..WIDTH-1; sum[WIDTH]=appc[WIDTH-1].
  - No carry-in.
- Exact function: sum = a+b, zero-extended to WIDTH+1 bits.
- NSEG = ceil(WIDTH/WIN). The last segment may be narrower than WIN.
- Input accept occurs when in_valid && in_ready. On accept, a/b/mode are latched.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back accept is allowed in the cycle a result is consumed.
- State machine:
  - IDLE: on accept with mode=0, load the approximate sum -> DONE (latency 1).
  - IDLE: on accept with mode=1, clear carry, seg=0 -> EXACT.
  - EXACT: each cycle, add slice seg of a and b plus the carry register; write the slice into sum; update carry; seg++.
    - After slice NSEG-1, write sum[WIDTH]=carry-out -> DONE.
    - Latency NSEG+1 cycles from accept to out_valid.
  - DONE: out_valid=1; sum/err held stable while out_ready=0.
    - out_ready=1 with a new accept: behave as IDLE accept.
    - out_ready=1 with no accept: -> IDLE.
- out_valid is deasserted in every state except DONE.
- Inputs a/b/mode are ignored outside an accept cycle. Changes during EXACT do not affect the result.
- rst asserted in any state, including mid-EXACT or while DONE with out_valid=1:
  - the in-flight operation is discarded and the result is never presented;
  - next cycle the block is in IDLE with reset values.

Optional Feature:
- Macro: RAP_ERRFLAG_EN.
- Defined:
  - port err exists;
  - in approximate mode, err is registered with sum and equals 1 iff the approximate sum != a+b;
  - err=0 for exact-mode results.
- Undefined: port err and its comparator are absent; all other behaviour is identical.

Decomposition:
- Package rapcla_pkg:
  - state enum {IDLE, EXACT, DONE};
  - function nseg(width, win) returning the ceiling division;
  - localparam for the segment-counter width, $clog2(NSEG) min 1.
- Sub-module rapcla_approx_core (purely combinational, WIDTH/WIN parametrised): inputs a, b; output the WIDTH+1 approximate sum.
- rapcla_seq instantiates rapcla_approx_core once.

Test Plan:
- WIDTH=16, WIN=4, mode=0, a=0x00FF, b=0x0001 -> out_valid 1 cycle after accept, sum=0x000C0, err=1.
- mode=0, a=0x1234, b=0x4321 -> sum=0x05555, err=0.
- mode=1, a=0xFFFF, b=0x0001 -> 4 EXACT cycles, out_valid on cycle 5, sum=0x10000, err=0.
- mode=0, a=0xFFFF, b=0x0001, out_ready held 0 for 3 cycles -> sum=0x0FFC0 stable, in_ready=0 throughout; on release, accept of the next operand in the same cycle.
- mode=1, rst pulsed during the 2nd EXACT cycle -> next cycle out_valid=0, sum=0, in_ready=1; a new op, mode=0, 0x0003+0x0005, then returns sum=0x00008.
- Random: 1000 ops with mixed mode and random out_ready -> exact results equal a+b; approximate results equal the reference appc model; no result lost or duplicated.
